alu_shift_unit: RTL and testbench
=================================

// Module: alu_shift_unit
// PURPOSE
//  Multicycle shift/rotate stage directly downstream of the ALU. The ALU's shift opcode (6)
//  passes operand A through unchanged; this block takes that result and shifts it one bit per
//  clock. It then presents the shifted value and the co/ovf/z/n flags to the register-write
//  path, in the same form the ALU presents its own results. The control FSM sequences it with
//  a start/busy/done handshake.
// PARAMETERS
//  W   8  datapath width; must match the ALU width
//  SW  4  shift-amount width; shamt range is 0..2**SW-1
// PORTS
//  clk     in   1      system clock, rising edge
//  rst     in   1      asynchronous reset, active-high
//  start   in   1      request a shift; sampled only in IDLE
//  op      in   3      0 LSL, 1 LSR, 2 ASR, 3 ROR, 4 ROL, 5 RRC (rotate right through carry), 6-7 PASS
//  shamt   in   SW     shift count
//  din     in   W      operand, taken from the ALU out port
//  cin     in   1      current carry flag; used by RRC and by the shamt==0 / PASS result
//  out     out  W      shifted result; held stable from done until the next accepted start
//  co      out  1      carry: the last bit shifted or rotated out
//  ovf     out  1      overflow; LSL only, else 0
//  z       out  1      1 when out==0
//  n       out  1      out[W-1]
//  busy    out  1      high while a shift is in progress
//  done    out  1      1-cycle pulse: result valid
// BEHAVIOUR
//  - Reset (async, rst=1): FSM goes to IDLE; out, co, ovf, z, n, busy, done all 0.
//    Asserting rst mid-operation aborts the shift; no done pulse is produced.
//  - FSM states: IDLE, SHIFT, DONE.
//    IDLE -> SHIFT on start when shamt!=0 and op<=5.
//      On that edge: load work register with din, load counter with shamt, load carry with cin,
//      clear sticky ovf, set busy.
//    IDLE -> DONE on start when shamt==0 or op>=6.
//      On that edge: work=din, carry=cin, ovf=0.
//    SHIFT: on each clock, apply one 1-bit step to work, update carry, decrement counter.
//      Go to DONE on the edge where the counter goes 1 -> 0.
//    DONE: done=1 and busy=0 for exactly one cycle, then return to IDLE. start is ignored in DONE.
//  - Latency: with start high at edge 0, done is high during the cycle after edge max(shamt,0)+1.
//    Examples: shamt=3 -> done after the 4th edge; shamt=0 -> after the 1st edge.
//  - Step rules (w = work register, c = carry):
//      LSL: c=w[W-1]; w={w[W-2:0],0}
//      LSR: c=w[0];   w={0,w[W-1:1]}
//      ASR: c=w[0];   w={w[W-1],w[W-1:1]}
//      ROR: c=w[0];   w={w[0],w[W-1:1]}
//      ROL: c=w[W-1]; w={w[W-2:0],w[W-1]}
//      RRC: c=w[0];   w={c_old,w[W-1:1]}
//  - Shift amounts >= W are not clamped; the block iterates bitwise.
//      LSL/LSR reach 0 with c=0 once shamt > W.
//      ASR saturates to all copies of the sign bit.
//      Rotates wrap modulo W; RRC wraps modulo W+1.
//  - ovf is sticky during LSL: set if w[W-1] changes at any step. It is 0 for every other op.
//  - out/co/ovf/z/n update only on the edge that enters DONE and hold until the next accepted
//    start. Mid-operation values are never visible on out.
//  - start while busy or in DONE is dropped; there is no queueing.
// TESTING
//  1. LSL din=0x81, shamt=1, cin=0 -> done after edge 2; out=0x02, co=1, ovf=1, z=0, n=0.
//  2. ASR din=0x80, shamt=3 -> busy for 3 cycles, done after edge 4; out=0xF0, co=0, n=1, ovf=0.
//  3. ROR din=0x01, shamt=9 -> done after edge 10; out=0x80, co=1, n=1 (wrap past W).
//  4. LSR din=0x01, shamt=0, cin=1 -> done after edge 1; out=0x01, co=1.
//     PASS op=7 din=0x5A gives the same timing; out=0x5A.
//  5. RRC din=0x01, cin=0, shamt=1 -> out=0x00, co=1, z=1.
//     Repeat with cin=1 -> out=0x80, co=1, n=1.
//  6. Start LSL shamt=5; pulse start again at cycle 2 -> the second start is ignored, one done only.
//     Separately, assert rst at cycle 3 -> busy=0, out=0, no done pulse.

Source files
------------

// File: rtl/alu_shift_unit.sv
// Multicycle shift/rotate stage behind the ALU: one bit per clock,
// start/busy/done handshake, ALU-style co/ovf/z/n flags.
module alu_shift_unit #(
  parameter int W  = 8,
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [SW-1:0] shamt,
  input  logic [W-1:0]  din,
  input  logic          cin,
  output logic [W-1:0]  out,
  output logic          co,
  output logic          ovf,
  output logic          z,
  output logic          n,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [W-1:0]  r_work;
  logic [SW-1:0] r_cnt;
  logic          r_carry;
  logic          r_ovf;
  logic [2:0]    r_op;

  logic [W-1:0]  r_out;
  logic          r_co;
  logic          r_ovf_o;
  logic          r_z;
  logic          r_n;
  logic          r_busy;
  logic          r_done;

  logic [W-1:0]  w_step;
  logic          w_c;
  logic          w_chg;
  logic          w_ovf;
  logic          w_last;
  logic          w_multi;

  assign out  = r_out;
  assign co   = r_co;
  assign ovf  = r_ovf_o;
  assign z    = r_z;
  assign n    = r_n;
  assign busy = r_busy;
  assign done = r_done;

  // One 1-bit step of the selected operation on the work register
  always_comb begin
    w_step = r_work;
    w_c    = r_carry;
    w_chg  = 1'b0;
    case (r_op)
      3'd0: begin
        w_c    = r_work[W-1];
        w_step = {r_work[W-2:0], 1'b0};
        w_chg  = r_work[W-1] ^ r_work[W-2];
      end
      3'd1: begin
        w_c    = r_work[0];
        w_step = {1'b0, r_work[W-1:1]};
      end
      3'd2: begin
        w_c    = r_work[0];
        w_step = {r_work[W-1], r_work[W-1:1]};
      end
      3'd3: begin
        w_c    = r_work[0];
        w_step = {r_work[0], r_work[W-1:1]};
      end
      3'd4: begin
        w_c    = r_work[W-1];
        w_step = {r_work[W-2:0], r_work[W-1]};
      end
      3'd5: begin
        w_c    = r_work[0];
        w_step = {r_carry, r_work[W-1:1]};
      end
      default: ;
    endcase
  end

  assign w_ovf   = r_ovf | w_chg;
  assign w_last  = (r_cnt == SW'(1));
  assign w_multi = (shamt != '0) && (op <= 3'd5);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_work  <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_op    <= '0;
      r_out   <= '0;
      r_co    <= 1'b0;
      r_ovf_o <= 1'b0;
      r_z     <= 1'b0;
      r_n     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_work  <= din;
            r_carry <= cin;
            r_ovf   <= 1'b0;
            r_op    <= op;
            if (w_multi) begin
              r_cnt   <= shamt;
              r_busy  <= 1'b1;
              r_state <= S_SHIFT;
            end else begin
              r_out   <= din;
              r_co    <= cin;
              r_ovf_o <= 1'b0;
              r_z     <= (din == '0);
              r_n     <= din[W-1];
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          r_work  <= w_step;
          r_carry <= w_c;
          r_ovf   <= w_ovf;
          r_cnt   <= r_cnt - SW'(1);
          if (w_last) begin
            r_out   <= w_step;
            r_co    <= w_c;
            r_ovf_o <= w_ovf;
            r_z     <= (w_step == '0);
            r_n     <= w_step[W-1];
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_shift_unit.sv
// Directed bench for alu_shift_unit: latency, busy length, result
// and flags per op, shamt boundaries, dropped start and reset abort.
module tb_alu_shift_unit;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] op;
  logic [3:0] shamt;
  logic [7:0] din;
  logic       cin;
  logic [7:0] out;
  logic       co;
  logic       ovf;
  logic       z;
  logic       n;
  logic       busy;
  logic       done;

  int total;
  int bad;
  int lat;
  int nbusy;
  int ndone;
  int first_done;

  alu_shift_unit #(.W(8), .SW(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .shamt(shamt),
    .din  (din),
    .cin  (cin),
    .out  (out),
    .co   (co),
    .ovf  (ovf),
    .z    (z),
    .n    (n),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op; lat = edge number (sampling edge = 1) after which done is seen
  task automatic do_op(input logic [2:0] o, input logic [3:0] s,
                       input logic [7:0] d, input logic c,
                       output int l, output int nb);
    @(negedge clk);
    op = o; shamt = s; din = d; cin = c; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    l  = 1;
    nb = busy ? 1 : 0;
    while (!done && l < 100) begin
      @(posedge clk);
      #1;
      l++;
      if (busy) nb++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic res(input string tag, input logic [11:0] exp);
    chk(tag, {20'd0, out, co, ovf, z, n}, {20'd0, exp});
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; start = 1'b0; op = '0; shamt = '0; din = '0; cin = 1'b0;
    #12;
    chk("reset_out", {24'd0, out}, 32'd0);
    chk("reset_flags", {26'd0, co, ovf, z, n, busy, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op(3'd0, 4'd1, 8'h81, 1'b0, lat, nbusy);
    chk("lsl1_lat", lat, 2);
    res("lsl1_res", {8'h02, 4'b1100});

    do_op(3'd2, 4'd3, 8'h80, 1'b0, lat, nbusy);
    chk("asr3_lat", lat, 4);
    chk("asr3_busy", nbusy, 3);
    res("asr3_res", {8'hF0, 4'b0001});

    do_op(3'd3, 4'd9, 8'h01, 1'b0, lat, nbusy);
    chk("ror9_lat", lat, 10);
    res("ror9_res", {8'h80, 4'b1001});

    do_op(3'd1, 4'd0, 8'h01, 1'b1, lat, nbusy);
    chk("lsr0_lat", lat, 1);
    chk("lsr0_busy", nbusy, 0);
    res("lsr0_res", {8'h01, 4'b1000});

    do_op(3'd7, 4'd5, 8'h5A, 1'b0, lat, nbusy);
    chk("pass_lat", lat, 1);
    res("pass_res", {8'h5A, 4'b0000});

    do_op(3'd5, 4'd1, 8'h01, 1'b0, lat, nbusy);
    chk("rrc_c0_lat", lat, 2);
    res("rrc_c0_res", {8'h00, 4'b1010});

    do_op(3'd5, 4'd1, 8'h01, 1'b1, lat, nbusy);
    res("rrc_c1_res", {8'h80, 4'b1001});

    do_op(3'd0, 4'd9, 8'hFF, 1'b0, lat, nbusy);
    chk("lsl9_lat", lat, 10);
    res("lsl9_res", {8'h00, 4'b0110});

    do_op(3'd5, 4'd9, 8'h01, 1'b0, lat, nbusy);
    res("rrc9_res", {8'h01, 4'b0000});

    do_op(3'd4, 4'd3, 8'h81, 1'b0, lat, nbusy);
    res("rol3_res", {8'h0C, 4'b0000});

    do_op(3'd2, 4'd15, 8'h80, 1'b0, lat, nbusy);
    chk("asr15_lat", lat, 16);
    res("asr15_res", {8'hFF, 4'b1001});

    // Second start during SHIFT must be dropped
    @(negedge clk);
    op = 3'd0; shamt = 4'd5; din = 8'h01; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0;
    first_done = 0;
    for (int e = 3; e <= 20; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (first_done == 0) first_done = e;
      end
    end
    chk("drop_ndone", ndone, 1);
    chk("drop_edge", first_done, 6);
    res("drop_res", {8'h20, 4'b0000});

    // Reset mid-shift aborts without a done pulse
    @(negedge clk);
    op = 3'd0; shamt = 4'd5; din = 8'hFF; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_out", {24'd0, out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int e = 0; e < 10; e++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("abort_ndone", ndone, 0);

    do_op(3'd1, 4'd2, 8'h0C, 1'b0, lat, nbusy);
    chk("post_rst_lat", lat, 3);
    res("post_rst_res", {8'h03, 4'b0000});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
